// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes, immediate
// formats, the ID/EX payload record and small class-property helpers.
package riscv_pkg;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Instruction class carried to execute on type_o
  typedef enum logic [3:0] {
    TYPE_NOP     = 4'd0,
    TYPE_ALU_REG = 4'd1,
    TYPE_ALU_IMM = 4'd2,
    TYPE_LOAD    = 4'd3,
    TYPE_STORE   = 4'd4,
    TYPE_BRANCH  = 4'd5,
    TYPE_JAL     = 4'd6,
    TYPE_JALR    = 4'd7,
    TYPE_LUI     = 4'd8,
    TYPE_AUIPC   = 4'd9,
    TYPE_ILLEGAL = 4'd10
  } instr_type_e;

  // Immediate encodings; IMM_NONE yields a zero immediate
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd_id;
    logic [2:0]  funct3;
    logic        funct7b5;
    instr_type_e itype;
  } idex_t;

  // A bubble carries no instruction and an all-zero payload
  localparam idex_t IDEX_BUBBLE = '{
    valid:    1'b0,
    pc:       32'd0,
    rs1_val:  32'd0,
    rs2_val:  32'd0,
    imm:      32'd0,
    rd_id:    5'd0,
    funct3:   3'd0,
    funct7b5: 1'b0,
    itype:    TYPE_NOP
  };

  function automatic instr_type_e decode_type(input logic [6:0] opcode);
    instr_type_e t;
    case (opcode)
      OPC_OP:     t = TYPE_ALU_REG;
      OPC_OP_IMM: t = TYPE_ALU_IMM;
      OPC_LOAD:   t = TYPE_LOAD;
      OPC_STORE:  t = TYPE_STORE;
      OPC_BRANCH: t = TYPE_BRANCH;
      OPC_JAL:    t = TYPE_JAL;
      OPC_JALR:   t = TYPE_JALR;
      OPC_LUI:    t = TYPE_LUI;
      OPC_AUIPC:  t = TYPE_AUIPC;
      default:    t = TYPE_ILLEGAL;
    endcase
    return t;
  endfunction

  // rs1 is unused only by the upper-immediate forms and JAL
  function automatic logic reads_rs1(input instr_type_e t);
    return !(t inside {TYPE_NOP, TYPE_LUI, TYPE_AUIPC, TYPE_JAL});
  endfunction

  // rs2 is additionally unused by every I-format class
  function automatic logic reads_rs2(input instr_type_e t);
    return reads_rs1(t) && !(t inside {TYPE_ALU_IMM, TYPE_LOAD, TYPE_JALR});
  endfunction

  // Classes whose rd field is not a destination register
  function automatic logic writes_rd(input instr_type_e t);
    return !(t inside {TYPE_NOP, TYPE_STORE, TYPE_BRANCH, TYPE_ILLEGAL});
  endfunction

  function automatic imm_fmt_e imm_fmt_of(input instr_type_e t);
    imm_fmt_e f;
    case (t)
      TYPE_ALU_IMM, TYPE_LOAD, TYPE_JALR: f = IMM_I;
      TYPE_STORE:                         f = IMM_S;
      TYPE_BRANCH:                        f = IMM_B;
      TYPE_LUI, TYPE_AUIPC:               f = IMM_U;
      TYPE_JAL:                           f = IMM_J;
      default:                            f = IMM_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the immediate field of the selected
// RV32I format. Purely combinational; the opcode bits are not needed.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  // Reassemble the scattered immediate bits for each format
  always_comb begin
    // NOTE: a default is assigned before the case so no path leaves imm_o
    // unassigned, which would otherwise infer a latch.
    imm_o = 32'd0;
    case (fmt_i)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'd0};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: classifies the fetched instruction, reads operands
// (with an optional writeback bypass), detects the load-use hazard and
// registers the decoded payload into the ID/EX register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        valid_i,
  input  logic        flush_i,
  output logic [4:0]  rs1Id_o,
  output logic [4:0]  rs2Id_o,
  input  logic [31:0] rs1Data_i,
  input  logic [31:0] rs2Data_i,
  input  logic [4:0]  wbRdId_i,
  input  logic [31:0] wbRdData_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] rs1Val_o,
  output logic [31:0] rs2Val_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rdId_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [3:0]  type_o
);

  instr_type_e itype;
  imm_fmt_e    imm_fmt;
  logic        uses_rs1;
  logic        uses_rs2;
  logic [4:0]  rd_id;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        hazard;
  idex_t       idex_d;
  idex_t       idex_q;

  // Classify the instruction; an empty slot decodes as NOP and reads nothing
  always_comb begin
    itype    = TYPE_NOP;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    rd_id    = 5'd0;
    if (valid_i) begin
      itype    = decode_type(instr_i[6:0]);
      uses_rs1 = reads_rs1(itype);
      uses_rs2 = reads_rs2(itype);
      rd_id    = writes_rd(itype) ? instr_i[11:7] : 5'd0;
    end
    imm_fmt = imm_fmt_of(itype);
  end

  assign rs1Id_o = uses_rs1 ? instr_i[19:15] : 5'd0;
  assign rs2Id_o = uses_rs2 ? instr_i[24:20] : 5'd0;

  imm_gen u_imm_gen (
    .instr_i (instr_i[31:7]),
    .fmt_i   (imm_fmt),
    .imm_o   (imm)
  );

  // Operand select: x0 reads as zero, and a same-cycle writeback to the
  // register being read wins over the (not yet updated) register file
  always_comb begin
    rs1_val = rs1Data_i;
    rs2_val = rs2Data_i;
    if (BYPASS_EN) begin
      if (rs1Id_o == 5'd0)           rs1_val = 32'd0;
      else if (wbRdId_i == rs1Id_o)  rs1_val = wbRdData_i;
      if (rs2Id_o == 5'd0)           rs2_val = 32'd0;
      else if (wbRdId_i == rs2Id_o)  rs2_val = wbRdData_i;
    end
  end

  // Load-use hazard: the load in ID/EX has not produced its data yet, so a
  // dependent instruction waits one cycle; a flush kills it instead
  always_comb begin
    hazard  = idex_q.valid && (idex_q.itype == TYPE_LOAD) &&
              (idex_q.rd_id != 5'd0) &&
              ((idex_q.rd_id == rs1Id_o) || (idex_q.rd_id == rs2Id_o)) &&
              valid_i;
    stall_o = hazard && !flush_i;
  end

  // Next ID/EX contents: a bubble unless a live, unstalled instruction is here
  always_comb begin
    idex_d = IDEX_BUBBLE;
    if (valid_i && !flush_i && !stall_o) begin
      idex_d = '{
        valid:    1'b1,
        pc:       pc_i,
        rs1_val:  rs1_val,
        rs2_val:  rs2_val,
        imm:      imm,
        rd_id:    rd_id,
        funct3:   instr_i[14:12],
        funct7b5: instr_i[30],
        itype:    itype
      };
    end
  end

  // ID/EX register with synchronous reset to a bubble
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its input from before the edge, independent of statement order.
    if (reset_i) idex_q <= IDEX_BUBBLE;
    else         idex_q <= idex_d;
  end

  assign valid_o    = idex_q.valid;
  assign pc_o       = idex_q.pc;
  assign rs1Val_o   = idex_q.rs1_val;
  assign rs2Val_o   = idex_q.rs2_val;
  assign imm_o      = idex_q.imm;
  assign rdId_o     = idex_q.rd_id;
  assign funct3_o   = idex_q.funct3;
  assign funct7b5_o = idex_q.funct7b5;
  assign type_o     = idex_q.itype;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a table of single-instruction vectors plus short
// hand-written sequences (load-use stall, flush, mid-stream reset). Expected
// ID/EX contents are queued when a vector is driven and compared one clock
// later. A second instance with the bypass disabled shares all inputs.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i, valid_i, flush_i;
  logic [31:0] instr_i, pc_i, rs1Data_i, rs2Data_i, wbRdData_i;
  logic [4:0]  wbRdId_i;

  logic [4:0]  rs1Id_o, rs2Id_o, rdId_o;
  logic        stall_o, valid_o, funct7b5_o;
  logic [31:0] pc_o, rs1Val_o, rs2Val_o, imm_o;
  logic [2:0]  funct3_o;
  logic [3:0]  type_o;

  logic [4:0]  nb_rs1Id, nb_rs2Id, nb_rdId;
  logic        nb_stall, nb_valid, nb_funct7b5;
  logic [31:0] nb_pc, nb_rs1Val, nb_rs2Val, nb_imm;
  logic [2:0]  nb_funct3;
  logic [3:0]  nb_type;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i(clk), .reset_i(reset_i), .instr_i(instr_i), .pc_i(pc_i),
    .valid_i(valid_i), .flush_i(flush_i), .rs1Id_o(rs1Id_o), .rs2Id_o(rs2Id_o),
    .rs1Data_i(rs1Data_i), .rs2Data_i(rs2Data_i), .wbRdId_i(wbRdId_i),
    .wbRdData_i(wbRdData_i), .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o),
    .rs1Val_o(rs1Val_o), .rs2Val_o(rs2Val_o), .imm_o(imm_o), .rdId_o(rdId_o),
    .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .type_o(type_o)
  );

  decode_stage #(.BYPASS_EN(1'b0)) dut_nb (
    .clk_i(clk), .reset_i(reset_i), .instr_i(instr_i), .pc_i(pc_i),
    .valid_i(valid_i), .flush_i(flush_i), .rs1Id_o(nb_rs1Id), .rs2Id_o(nb_rs2Id),
    .rs1Data_i(rs1Data_i), .rs2Data_i(rs2Data_i), .wbRdId_i(wbRdId_i),
    .wbRdData_i(wbRdData_i), .stall_o(nb_stall), .valid_o(nb_valid), .pc_o(nb_pc),
    .rs1Val_o(nb_rs1Val), .rs2Val_o(nb_rs2Val), .imm_o(nb_imm), .rdId_o(nb_rdId),
    .funct3_o(nb_funct3), .funct7b5_o(nb_funct7b5), .type_o(nb_type)
  );

  // One vector: inputs, expected combinational outputs, expected ID/EX
  typedef struct {
    logic        rst, vld, fl;
    logic [31:0] instr, pc, rs1d, rs2d;
    logic [4:0]  wbid;
    logic [31:0] wbd;
    logic        e_stall;
    logic [4:0]  e_rs1id, e_rs2id;
    logic        e_valid;
    instr_type_e e_type;
    logic [4:0]  e_rd;
    logic [2:0]  e_f3;
    logic        e_f7;
    logic [31:0] e_imm, e_rs1v, e_rs2v, e_rs1v_nb, e_rs2v_nb;
  } row_t;

  typedef struct {
    string       tag;
    logic        valid;
    instr_type_e itype;
    logic [31:0] pc, imm, rs1v, rs2v, rs1v_nb, rs2v_nb;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  // Drive one vector, check the combinational outputs, then the registered
  // payload after the next rising edge
  task automatic apply(input row_t v, input string tag);
    exp_t e, got;
    @(negedge clk);
    reset_i = v.rst;  valid_i = v.vld;  flush_i = v.fl;
    instr_i = v.instr; pc_i = v.pc;
    rs1Data_i = v.rs1d; rs2Data_i = v.rs2d;
    wbRdId_i = v.wbid; wbRdData_i = v.wbd;
    #1;
    check(tag, "stall_o", 32'(stall_o), 32'(v.e_stall));
    check(tag, "rs1Id_o", 32'(rs1Id_o), 32'(v.e_rs1id));
    check(tag, "rs2Id_o", 32'(rs2Id_o), 32'(v.e_rs2id));
    e.tag = tag; e.valid = v.e_valid; e.itype = v.e_type;
    e.pc = v.e_valid ? v.pc : 32'd0;
    e.imm = v.e_imm; e.rs1v = v.e_rs1v; e.rs2v = v.e_rs2v;
    e.rs1v_nb = v.e_rs1v_nb; e.rs2v_nb = v.e_rs2v_nb;
    e.rd = v.e_rd; e.f3 = v.e_f3; e.f7 = v.e_f7;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check(tag, "scoreboard empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check(got.tag, "valid_o",    32'(valid_o),    32'(got.valid));
      check(got.tag, "type_o",     32'(type_o),     32'(got.itype));
      check(got.tag, "pc_o",       pc_o,            got.pc);
      check(got.tag, "imm_o",      imm_o,           got.imm);
      check(got.tag, "rdId_o",     32'(rdId_o),     32'(got.rd));
      check(got.tag, "funct3_o",   32'(funct3_o),   32'(got.f3));
      check(got.tag, "funct7b5_o", 32'(funct7b5_o), 32'(got.f7));
      check(got.tag, "rs1Val_o",   rs1Val_o,        got.rs1v);
      check(got.tag, "rs2Val_o",   rs2Val_o,        got.rs2v);
      check(got.tag, "nb rs1Val_o", nb_rs1Val,      got.rs1v_nb);
      check(got.tag, "nb rs2Val_o", nb_rs2Val,      got.rs2v_nb);
      check(got.tag, "nb valid_o", 32'(nb_valid),   32'(got.valid));
    end
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] ADD  = 32'h0020_81B3;  // add  x3,x1,x2
  localparam logic [31:0] LW   = 32'h0001_2283;  // lw   x5,0(x2)
  localparam logic [31:0] ADDD = 32'h0052_8333;  // add  x6,x5,x5

  row_t tbl[13];

  initial begin
    // rst vld fl instr pc rs1d rs2d wbid wbd | stall id1 id2 | valid type rd f3 f7 imm rs1v rs2v rs1v_nb rs2v_nb
    tbl[0]  = '{1,1,0, ADDI, 32'h100, 0, 0, 0, 0,
                0, 0, 0, 0, TYPE_NOP, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0,1,0, ADDI, 32'h100, 32'h1111_1111, 32'h22, 0, 0,
                0, 0, 0, 1, TYPE_ALU_IMM, 1, 0, 0, 5, 0, 0, 32'h1111_1111, 32'h22};
    tbl[2]  = '{0,1,0, ADD, 32'h104, 0, 32'h22, 1, 32'hDEAD_BEEF,
                0, 1, 2, 1, TYPE_ALU_REG, 3, 0, 0, 0, 32'hDEAD_BEEF, 32'h22, 0, 32'h22};
    tbl[3]  = '{0,1,0, 32'h4011_8233, 32'h108, 32'h30, 32'h10, 3, 32'hABCD,
                0, 3, 1, 1, TYPE_ALU_REG, 4, 0, 1, 0, 32'hABCD, 32'h10, 32'h30, 32'h10};
    tbl[4]  = '{0,1,0, 32'hFE51_2E23, 32'h10C, 32'h1000, 32'h55, 5, 32'h77,
                0, 2, 5, 1, TYPE_STORE, 0, 2, 1, 32'hFFFF_FFFC, 32'h1000, 32'h77, 32'h1000, 32'h55};
    tbl[5]  = '{0,1,0, 32'hFE20_8CE3, 32'h110, 32'hA, 32'hB, 0, 32'h99,
                0, 1, 2, 1, TYPE_BRANCH, 0, 0, 1, 32'hFFFF_FFF8, 32'hA, 32'hB, 32'hA, 32'hB};
    tbl[6]  = '{0,1,0, 32'h1234_53B7, 32'h114, 3, 4, 0, 0,
                0, 0, 0, 1, TYPE_LUI, 7, 5, 0, 32'h1234_5000, 0, 0, 3, 4};
    tbl[7]  = '{0,1,0, 32'h0100_00EF, 32'h118, 5, 6, 0, 0,
                0, 0, 0, 1, TYPE_JAL, 1, 0, 0, 16, 0, 0, 5, 6};
    tbl[8]  = '{0,1,0, 32'h0000_8067, 32'h11C, 32'h200, 9, 0, 0,
                0, 1, 0, 1, TYPE_JALR, 0, 0, 0, 0, 32'h200, 0, 32'h200, 9};
    tbl[9]  = '{0,1,0, 32'hFFFF_F517, 32'h120, 0, 0, 0, 0,
                0, 0, 0, 1, TYPE_AUIPC, 10, 7, 1, 32'hFFFF_F000, 0, 0, 0, 0};
    tbl[10] = '{0,1,0, 32'h0000_0000, 32'h124, 0, 0, 0, 0,
                0, 0, 0, 1, TYPE_ILLEGAL, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0,0,0, ADD, 32'h128, 1, 2, 0, 0,
                0, 0, 0, 0, TYPE_NOP, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{0,1,0, ADDI, 32'h12C, 0, 0, 0, 32'hFFFF_FFFF,
                0, 0, 0, 1, TYPE_ALU_IMM, 1, 0, 0, 5, 0, 0, 0, 0};

    reset_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    instr_i = '0; pc_i = '0; rs1Data_i = '0; rs2Data_i = '0;
    wbRdId_i = '0; wbRdData_i = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Load-use: one stall cycle, one bubble, then the dependent add issues
    apply('{0,1,0, LW, 32'h200, 32'h400, 0, 0, 0,
            0, 2, 0, 1, TYPE_LOAD, 5, 2, 0, 0, 32'h400, 0, 32'h400, 0}, "lu_load");
    apply('{0,1,0, ADDD, 32'h204, 32'h1234, 32'h1234, 0, 0,
            1, 5, 5, 0, TYPE_NOP, 0, 0, 0, 0, 0, 0, 0, 0}, "lu_stall");
    apply('{0,1,0, ADDD, 32'h204, 32'h1234, 32'h1234, 5, 32'hCAFE,
            0, 5, 5, 1, TYPE_ALU_REG, 6, 0, 0, 0, 32'hCAFE, 32'hCAFE, 32'h1234, 32'h1234}, "lu_issue");

    // Flush during the load-use cycle: no stall, bubble loaded
    apply('{0,1,0, LW, 32'h300, 32'h400, 0, 0, 0,
            0, 2, 0, 1, TYPE_LOAD, 5, 2, 0, 0, 32'h400, 0, 32'h400, 0}, "fl_load");
    apply('{0,1,1, ADDD, 32'h304, 32'h1234, 32'h1234, 0, 0,
            0, 5, 5, 0, TYPE_NOP, 0, 0, 0, 0, 0, 0, 0, 0}, "fl_kill");
    apply('{0,0,0, ADDD, 32'h308, 0, 0, 0, 0,
            0, 0, 0, 0, TYPE_NOP, 0, 0, 0, 0, 0, 0, 0, 0}, "fl_idle");

    // Reset pulse mid-stream: the captured load is dropped, no stall follows
    apply('{0,1,0, LW, 32'h400, 32'h400, 0, 0, 0,
            0, 2, 0, 1, TYPE_LOAD, 5, 2, 0, 0, 32'h400, 0, 32'h400, 0}, "rs_load");
    apply('{1,1,0, ADDI, 32'h404, 0, 0, 0, 0,
            0, 0, 0, 0, TYPE_NOP, 0, 0, 0, 0, 0, 0, 0, 0}, "rs_pulse");
    apply('{0,1,0, ADDD, 32'h408, 32'h42, 32'h42, 0, 0,
            0, 5, 5, 1, TYPE_ALU_REG, 6, 0, 0, 0, 32'h42, 32'h42, 32'h42, 32'h42}, "rs_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: BYPASS_EN, default 1, enables the writeback-to-decode bypass (0 = register-file data used unmodified).
REQ-002 One clock; reset is synchronous and active-high; the ports are clk_i and reset_i.
REQ-003 clk_i  in  1  clock; all state updates on the rising edge.
REQ-004 reset_i  in  1  synchronous active-high reset.
REQ-005 instr_i  in  32  fetched instruction (IF/ID payload).
REQ-006 pc_i  in  32  PC of instr_i.
REQ-007 valid_i  in  1  instr_i/pc_i hold a real instruction.
REQ-008 flush_i  in  1  redirect from execute; kills the instruction currently in decode.
REQ-009 rs1Id_o, rs2Id_o  out  5 each  register-file read addresses (combinational).
REQ-010 rs1Data_i, rs2Data_i  in  32 each  register-file read data (asynchronous, same cycle).
REQ-011 wbRdId_i  in  5, wbRdData_i  in  32  the writeback port also driving the register file.
REQ-012 stall_o  out  1  combinational; fetch holds pc_i/instr_i while high.
REQ-013 valid_o  out  1  the ID/EX register holds a real instruction.
REQ-014 pc_o  out  32; rs1Val_o, rs2Val_o  out  32 each; imm_o  out  32; rdId_o  out  5; funct3_o  out  3; funct7b5_o  out  1; type_o  out  4  (ID/EX register payload).

Function
REQ-015 type_o classes are NOP, ALU_REG, ALU_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC and ILLEGAL, decoded from opcode instr_i[6:0].
REQ-016 rs1Id_o = instr_i[19:15] and rs2Id_o = instr_i[24:20]; each is forced to 0 when the class does not read it (LUI/AUIPC/JAL: both; ALU_IMM/LOAD/JALR: rs2) or when valid_i=0.
REQ-017 Bypass (BYPASS_EN=1): when wbRdId_i!=0 and wbRdId_i==rsXId_o, the captured operand is wbRdData_i; otherwise it is rsXData_i. Address x0 always yields 0.
REQ-018 imm_o is sign-extended per the I/S/B/U/J format of the class; it is 0 for ALU_REG, NOP and ILLEGAL.
REQ-019 rdId_o = instr_i[11:7], forced to 0 for STORE, BRANCH and ILLEGAL.
REQ-020 Latency: the decoded payload appears on the ID/EX outputs one clock after capture.
REQ-021 Load-use hazard: hazard = valid_o & (type_o==LOAD) & (rdId_o!=0) & (rdId_o==rs1Id_o | rdId_o==rs2Id_o) & valid_i.
REQ-022 stall_o = hazard & ~flush_i.
REQ-023 While stall_o is high, the ID/EX register loads a bubble; instr_i is re-decoded on the next cycle, so the hazard lasts exactly one cycle.
REQ-024 flush_i=1 loads a bubble, overriding stall and valid_i.
REQ-025 valid_i=0 loads a bubble.
REQ-026 Bubble: valid_o=0, type_o=NOP, and every payload field = 0.
REQ-027 An ILLEGAL instruction passes with valid_o=1 and type_o=ILLEGAL; execute owns the trap.

Reset
REQ-028 reset_i=1 at a clock edge clears valid_o and all payload outputs to 0 and sets type_o=NOP, regardless of flush_i or valid_i.
REQ-029 During reset, stall_o=0, because valid_o=0 after the first reset edge.
REQ-030 An instruction in flight when reset is asserted is discarded and not replayed.

Structure
REQ-031 Package riscv_pkg shall hold the opcode constants, the 4-bit type_o enumeration and the immediate-format enumeration.
REQ-032 One sub-module, imm_gen, shall be purely combinational: it takes the instruction and format and produces the 32-bit immediate.
REQ-033 The ID/EX register and the hazard logic shall reside in decode_stage.

Verification
REQ-034 addi x1,x0,5 (0x00500093), pc_i=0x100 -> next cycle: valid_o=1, type_o=ALU_IMM, rdId_o=1, imm_o=5, pc_o=0x100, rs2Id_o=0.
REQ-035 add x3,x1,x2 (0x002081B3), rs1Data_i=0, wbRdId_i=1, wbRdData_i=0xDEADBEEF -> rs1Val_o=0xDEADBEEF; with BYPASS_EN=0 -> rs1Val_o=0.
REQ-036 lw x5,0(x2) (0x00012283) then add x6,x5,x5 (0x00528333) -> stall_o=1 for one cycle, one bubble (valid_o=0), then add issues with valid_o=1 and rdId_o=6.
REQ-037 flush_i=1 during the load-use cycle of REQ-036 -> stall_o=0; next cycle valid_o=0 and all payload = 0.
REQ-038 rs1 = x0 with wbRdId_i=0 and wbRdData_i=0xFFFFFFFF -> rs1Val_o=0; a STORE -> rdId_o=0.
REQ-039 reset_i pulsed for one cycle mid-stream with valid_i=1 -> next cycle valid_o=0, type_o=NOP, payload = 0, stall_o=0.
